fpu_ss_req_arbiter: RTL and testbench
=====================================

Name: fpu_ss_req_arbiter

Overview:
- Shares one FPU subsystem between NUM_REQ offloading cores (harts).
- Round-robin arbitration of the per-requester C-request channels onto the single downstream C-request channel; tags each request with the requester index as hart_id.
- Routes C-responses back to the requester named by the returned hart_id.
- Per-requester outstanding-instruction counters throttle each requester to MAX_OUTSTANDING.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MAX_OUTSTANDING, 4, maximum in-flight requests per requester (1..15).
- ADDR_WIDTH, acc_pkg::AddrWidth, width of the request addr field.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester request ready.
- req_addr_i  in  NUM_REQ x ADDR_WIDTH  accelerator address.
- req_rs_i  in  NUM_REQ x 3 x 32  integer operands.
- req_instr_i  in  NUM_REQ x 32  instruction word.
- c_q_valid_o  out  1  downstream request valid.
- c_q_ready_i  in  1  downstream request ready.
- c_q_addr_o / c_q_rs_o / c_q_instr_data_o  out  ADDR_WIDTH / 3x32 / 32  muxed payload.
- c_q_hart_id_o  out  32  granted index, zero-extended.
- c_p_valid_i  in  1  downstream response valid.
- c_p_ready_o  out  1  downstream response ready.
- c_p_data_i  in  32  response data.
- c_p_rd_i  in  5  destination register.
- c_p_hart_id_i  in  32  response owner.
- rsp_valid_o  out  NUM_REQ  per-requester response valid.
- rsp_ready_i  in  NUM_REQ  per-requester response ready.
- rsp_data_o  out  32  broadcast response data.
- rsp_rd_o  out  5  broadcast destination register.
- outstanding_o  out  NUM_REQ x 4  per-requester in-flight count.
- err_o  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_i=1):
  - rr_ptr=0, lock=0, all counters=0, err_o=0.
  - All valid/ready outputs 0; payload outputs 0.
- Eligibility: elig[i] = req_valid_i[i] & (cnt[i] < MAX_OUTSTANDING).
- States IDLE / LOCKED (lock bit plus registered grant index gnt_q):
  - IDLE: pick the first eligible index searching from rr_ptr upward, wrapping; drive c_q_valid_o=1 with that requester's payload, combinationally, in the same cycle (zero-cycle latency).
  - IDLE, c_q_ready_i=0: go to LOCKED with gnt_q = winner. Grant does not change until handshake (AXI-style stability; payload held constant).
  - LOCKED: c_q_valid_o=1 with gnt_q's payload, independent of req_valid_i. A requester must not drop valid once offered.
  - Handshake in either state: req_ready_o[g]=c_q_ready_i for the granted g only; others 0. Next state IDLE, rr_ptr=(g+1) mod NUM_REQ.
  - No eligible requester in IDLE: c_q_valid_o=0, rr_ptr unchanged.
- Response routing:
  - o = c_p_hart_id_i.
  - If o < NUM_REQ and cnt[o] != 0: rsp_valid_o[o] = c_p_valid_i and c_p_ready_o = rsp_ready_i[o].
  - Otherwise the response is invalid: c_p_ready_o=1 (dropped), err_o set, cleared only by reset.
  - rsp_data_o / rsp_rd_o pass through combinationally.
- Counters, 4-bit:
  - cnt[i] +1 on request handshake to i.
  - cnt[i] −1 on valid response handshake to i.
  - Both in the same cycle to the same i: unchanged.
  - cnt never exceeds MAX_OUTSTANDING and never underflows; the guards above enforce this.
- Reset mid-transaction: lock and counters clear immediately; in-flight downstream responses after reset are flagged via err_o.

Decomposition:
- fpu_ss_pkg gains:
  - fpu_ss_req_t: packed struct {addr, rs[3], instr_data}.
  - CNT_WIDTH = 4.
- One sub-module, fpu_ss_rr_arb: parameterised NUM_REQ round-robin priority picker (inputs elig, rr_ptr; outputs onehot and index; combinational).
- Lock, counters and response routing live in the top module.

Test Plan:
- Both requesters continuously valid, c_q_ready_i=1, responses returned promptly -> grants alternate 0,1,0,1; hart_id_o alternates 0,1.
- Requester 0 valid, c_q_ready_i=0 for 3 cycles, requester 1 raises valid in cycle 2 -> grant and payload stay on 0 for all 3 cycles; handshake on cycle 4; then 1 is granted.
- Requester 1 issues 4 requests with no responses -> outstanding_o[1]=4, req_ready_o[1] stays 0 while requester 0 is still granted; one response for hart 1 -> count 3, requester 1 re-eligible next cycle.
- Request handshake and response handshake to requester 0 in the same cycle with cnt[0]=2 -> cnt[0]=2 next cycle.
- Response with hart_id=5 (NUM_REQ=2) or to a requester with cnt=0 -> c_p_ready_o=1, no rsp_valid_o asserted, err_o=1 persisting until rst_i.
- rst_i asserted while LOCKED with cnt=3 -> all outputs 0 asynchronously; after release the first grant goes to index 0.

Source files
------------

// File: rtl/fpu_ss_pkg.sv
// Shared types and constants for the FPU subsystem request arbiter.
package fpu_ss_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned CNT_WIDTH = 4;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [2:0][31:0]     rs;
    logic [31:0]          instr_data;
  } fpu_ss_req_t;

endpackage

// File: rtl/fpu_ss_rr_arb.sv
// Combinational round-robin picker: first eligible index at or above rr_ptr, wrapping.
module fpu_ss_rr_arb #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  logic        found;
  int unsigned j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (k + 32'(rr_ptr)) % NUM_REQ;
      if (!found && elig[IDX_W'(j)]) begin
        found              = 1'b1;
        idx                = IDX_W'(j);
        onehot[IDX_W'(j)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_ss_req_arbiter.sv
// Shares one FPU subsystem between NUM_REQ harts: round-robin request arbitration
// with grant locking, hart_id response routing and per-hart in-flight throttling.
module fpu_ss_req_arbiter
  import fpu_ss_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_WIDTH      = AddrWidth
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_REQ-1:0]                    req_valid_i,
  output logic [NUM_REQ-1:0]                    req_ready_o,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ-1:0][2:0][31:0]         req_rs_i,
  input  logic [NUM_REQ-1:0][31:0]              req_instr_i,
  output logic                                  c_q_valid_o,
  input  logic                                  c_q_ready_i,
  output logic [ADDR_WIDTH-1:0]                 c_q_addr_o,
  output logic [2:0][31:0]                      c_q_rs_o,
  output logic [31:0]                           c_q_instr_data_o,
  output logic [31:0]                           c_q_hart_id_o,
  input  logic                                  c_p_valid_i,
  output logic                                  c_p_ready_o,
  input  logic [31:0]                           c_p_data_i,
  input  logic [4:0]                            c_p_rd_i,
  input  logic [31:0]                           c_p_hart_id_i,
  output logic [NUM_REQ-1:0]                    rsp_valid_o,
  input  logic [NUM_REQ-1:0]                    rsp_ready_i,
  output logic [31:0]                           rsp_data_o,
  output logic [4:0]                            rsp_rd_o,
  output logic [NUM_REQ-1:0][CNT_WIDTH-1:0]     outstanding_o,
  output logic                                  err_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_REQ - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]                         state_q;
  logic [IDX_W-1:0]                   gnt_q;
  logic [IDX_W-1:0]                   rr_ptr_q;
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0]  cnt_q;
  logic                               err_q;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] arb_onehot;
  logic [IDX_W-1:0]   arb_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [IDX_W-1:0]   gnt;
  logic               locked;
  logic               q_valid;
  logic               q_hs;

  logic               rsp_in_range;
  logic [IDX_W-1:0]   rsp_idx;
  logic               rsp_ok;
  logic               rsp_hs;
  logic [NUM_REQ-1:0] cnt_inc;
  logic [NUM_REQ-1:0] cnt_dec;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid_i[i] && (cnt_q[i] < CNT_MAX);
    end
  end

  fpu_ss_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arb (
    .elig   (elig),
    .rr_ptr (rr_ptr_q),
    .onehot (arb_onehot),
    .idx    (arb_idx)
  );

  // A locked grant is offered regardless of the requester's current valid.
  assign locked  = (state_q == LOCKED);
  assign q_valid = !rst_i && (locked || (|elig));
  assign gnt     = locked ? gnt_q : arb_idx;
  assign q_hs    = q_valid && c_q_ready_i;

  always_comb begin
    gnt_oh = '0;
    if (locked) gnt_oh[gnt_q] = 1'b1;
    else        gnt_oh        = arb_onehot;
  end

  assign req_ready_o      = q_hs ? gnt_oh : '0;
  assign c_q_valid_o      = q_valid;
  assign c_q_addr_o       = q_valid ? req_addr_i[gnt]  : '0;
  assign c_q_rs_o         = q_valid ? req_rs_i[gnt]    : '0;
  assign c_q_instr_data_o = q_valid ? req_instr_i[gnt] : '0;
  assign c_q_hart_id_o    = q_valid ? 32'(gnt)         : '0;

  // A response is only accepted for an existing hart that has work in flight.
  assign rsp_in_range = (c_p_hart_id_i < 32'(NUM_REQ));
  assign rsp_idx      = c_p_hart_id_i[IDX_W-1:0];
  assign rsp_ok       = rsp_in_range && (cnt_q[rsp_idx] != '0);
  assign rsp_hs       = c_p_valid_i && rsp_ok && rsp_ready_i[rsp_idx];

  always_comb begin
    rsp_valid_o = '0;
    c_p_ready_o = 1'b0;
    if (!rst_i) begin
      if (rsp_ok) begin
        rsp_valid_o[rsp_idx] = c_p_valid_i;
        c_p_ready_o          = rsp_ready_i[rsp_idx];
      end else begin
        c_p_ready_o = 1'b1;
      end
    end
  end

  assign rsp_data_o    = rst_i ? '0 : c_p_data_i;
  assign rsp_rd_o      = rst_i ? '0 : c_p_rd_i;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (q_hs) begin
        state_q  <= IDLE;
        rr_ptr_q <= (gnt == IDX_LAST) ? '0 : gnt + IDX_W'(1);
      end else if (q_valid && !locked) begin
        state_q <= LOCKED;
        gnt_q   <= arb_idx;
      end
      if (c_p_valid_i && !rsp_ok) err_q <= 1'b1;
    end
  end

  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_inc[i] = q_hs   && (gnt == IDX_W'(i));
      cnt_dec[i] = rsp_hs && (rsp_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (cnt_inc[i] && !cnt_dec[i])      cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
        else if (cnt_dec[i] && !cnt_inc[i]) cnt_q[i] <= cnt_q[i] - CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fpu_ss_req_arbiter.sv
// Self-checking bench for fpu_ss_req_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_fpu_ss_req_arbiter;

  localparam int N    = 2;
  localparam int MAXO = 4;
  localparam int AW   = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N-1:0]          req_valid = '0;
  logic [N-1:0]          req_ready;
  logic [N-1:0][AW-1:0]  req_addr = '0;
  logic [N-1:0][2:0][31:0] req_rs = '0;
  logic [N-1:0][31:0]    req_instr = '0;
  logic                  c_q_valid;
  logic                  c_q_ready = 1'b0;
  logic [AW-1:0]         c_q_addr;
  logic [2:0][31:0]      c_q_rs;
  logic [31:0]           c_q_instr;
  logic [31:0]           c_q_hart;
  logic                  c_p_valid = 1'b0;
  logic                  c_p_ready;
  logic [31:0]           c_p_data = '0;
  logic [4:0]            c_p_rd = '0;
  logic [31:0]           c_p_hart = '0;
  logic [N-1:0]          rsp_valid;
  logic [N-1:0]          rsp_ready = '0;
  logic [31:0]           rsp_data;
  logic [4:0]            rsp_rd;
  logic [N-1:0][3:0]     outstanding;
  logic                  err;

  int errors = 0;
  int checks = 0;

  int m_cnt[N];
  int m_ptr;
  bit m_locked;
  int m_gnt;
  bit m_err;

  fpu_ss_req_arbiter #(
    .NUM_REQ         (N),
    .MAX_OUTSTANDING (MAXO),
    .ADDR_WIDTH      (AW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_addr_i       (req_addr),
    .req_rs_i         (req_rs),
    .req_instr_i      (req_instr),
    .c_q_valid_o      (c_q_valid),
    .c_q_ready_i      (c_q_ready),
    .c_q_addr_o       (c_q_addr),
    .c_q_rs_o         (c_q_rs),
    .c_q_instr_data_o (c_q_instr),
    .c_q_hart_id_o    (c_q_hart),
    .c_p_valid_i      (c_p_valid),
    .c_p_ready_o      (c_p_ready),
    .c_p_data_i       (c_p_data),
    .c_p_rd_i         (c_p_rd),
    .c_p_hart_id_i    (c_p_hart),
    .rsp_valid_o      (rsp_valid),
    .rsp_ready_i      (rsp_ready),
    .rsp_data_o       (rsp_data),
    .rsp_rd_o         (rsp_rd),
    .outstanding_o    (outstanding),
    .err_o            (err)
  );

  always #5 clk = ~clk;

  // Reference model: who should be offered, derived from the arbitration rules.
  function automatic void m_pick(output bit v, output int g);
    v = 1'b0;
    g = 0;
    if (m_locked) begin
      v = 1'b1;
      g = m_gnt;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!v && req_valid[j] && m_cnt[j] < MAXO) begin
          v = 1'b1;
          g = j;
        end
      end
    end
  endfunction

  function automatic void m_rsp(output bit ok, output int o);
    ok = 1'b0;
    o  = 0;
    if (c_p_hart < N) begin
      o  = int'(c_p_hart);
      ok = (m_cnt[o] != 0);
    end
  endfunction

  function automatic void m_clock();
    bit v, ok;
    int g, o;
    m_pick(v, g);
    m_rsp(ok, o);
    if (v && c_q_ready) begin
      m_cnt[g]++;
      m_ptr    = (g + 1) % N;
      m_locked = 1'b0;
    end else if (v) begin
      m_locked = 1'b1;
      m_gnt    = g;
    end
    if (c_p_valid && ok && rsp_ready[o]) m_cnt[o]--;
    if (c_p_valid && !ok) m_err = 1'b1;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr    = 0;
    m_locked = 1'b0;
    m_gnt    = 0;
    m_err    = 1'b0;
  endfunction

  task automatic tick();
    m_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    c_q_ready = 1'b0;
    c_p_valid = 1'b0;
    c_p_hart  = '0;
    rsp_ready = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    m_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic set_payloads();
    for (int i = 0; i < N; i++) begin
      req_addr[i]  = $urandom;
      req_instr[i] = $urandom;
      for (int r = 0; r < 3; r++) req_rs[i][r] = $urandom;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_payloads();
    req_valid = '1; c_q_ready = 1'b1; c_p_valid = 1'b1; rsp_ready = '1;
    c_p_data = 32'hDEAD_BEEF; c_p_rd = 5'd7; c_p_hart = 32'd0;
    #3;
    checks++;
    if ({c_q_valid, req_ready, c_p_ready, rsp_valid, err} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0", {c_q_valid, req_ready, c_p_ready, rsp_valid, err});
    end
    checks++;
    if ({c_q_addr, c_q_rs, c_q_instr, c_q_hart, rsp_data, rsp_rd, outstanding} !== '0) begin
      errors++;
      $display("FAIL reset_payload: got nonzero addr=%0h hart=%0h data=%0h cnt=%0h expected 0",
               c_q_addr, c_q_hart, rsp_data, outstanding);
    end
    apply_reset();
  endtask

  task automatic test_alternate();
    apply_reset();
    set_payloads();
    req_valid = '1; c_q_ready = 1'b1; rsp_ready = '1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        c_p_valid = 1'b1; c_p_hart = 32'((i - 1) % 2); c_p_data = $urandom; c_p_rd = 5'($urandom);
      end else begin
        c_p_valid = 1'b0;
      end
      #1;
      checks++;
      if (c_q_hart !== 32'(i % 2) || c_q_addr !== req_addr[i % 2]) begin
        errors++;
        $display("FAIL alt_grant[%0d]: got hart=%0d addr=%0h expected hart=%0d addr=%0h",
                 i, c_q_hart, c_q_addr, i % 2, req_addr[i % 2]);
      end
      checks++;
      if (req_ready !== 2'(1 << (i % 2))) begin
        errors++;
        $display("FAIL alt_ready[%0d]: got %b expected %b", i, req_ready, 2'(1 << (i % 2)));
      end
      if (i > 0) begin
        checks++;
        if (rsp_valid !== 2'(1 << ((i - 1) % 2)) || rsp_data !== c_p_data || rsp_rd !== c_p_rd) begin
          errors++;
          $display("FAIL alt_rsp[%0d]: got valid=%b data=%0h rd=%0d expected valid=%b data=%0h rd=%0d",
                   i, rsp_valid, rsp_data, rsp_rd, 2'(1 << ((i - 1) % 2)), c_p_data, c_p_rd);
        end
      end
      tick();
    end
    c_p_valid = 1'b0;
    req_valid = '0;
    #1;
    checks++;
    if (outstanding !== {4'd1, 4'd0}) begin
      errors++;
      $display("FAIL alt_count: got %h expected 10", outstanding);
    end
  endtask

  task automatic test_lock_hold();
    logic [AW-1:0] a0;
    apply_reset();
    set_payloads();
    a0 = req_addr[0];
    req_valid = 2'b01; c_q_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) req_valid = 2'b11;
      #1;
      checks++;
      if ({c_q_valid, req_ready} !== 3'b100 || c_q_hart !== 32'd0 || c_q_addr !== a0) begin
        errors++;
        $display("FAIL lock_hold[%0d]: got v/rdy=%b hart=%0d addr=%0h expected 100 hart=0 addr=%0h",
                 c, {c_q_valid, req_ready}, c_q_hart, c_q_addr, a0);
      end
      tick();
    end
    c_q_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01 || c_q_hart !== 32'd0) begin
      errors++;
      $display("FAIL lock_hs: got rdy=%b hart=%0d expected 01 hart=0", req_ready, c_q_hart);
    end
    tick();
    checks++;
    if (req_ready !== 2'b10 || c_q_hart !== 32'd1 || c_q_addr !== req_addr[1]) begin
      errors++;
      $display("FAIL lock_next: got rdy=%b hart=%0d expected 10 hart=1", req_ready, c_q_hart);
    end
    tick();
    req_valid = '0;
    #1;
  endtask

  task automatic test_throttle();
    apply_reset();
    set_payloads();
    req_valid = 2'b10; c_q_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (outstanding[1] !== 4'd4) begin
      errors++;
      $display("FAIL thr_count_full: got %0d expected 4", outstanding[1]);
    end
    req_valid = 2'b11; c_q_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (req_ready !== 2'b00 || c_q_hart !== 32'd0 || c_q_valid !== 1'b1) begin
        errors++;
        $display("FAIL thr_blocked[%0d]: got rdy=%b hart=%0d v=%b expected 00 hart=0 v=1",
                 k, req_ready, c_q_hart, c_q_valid);
      end
      tick();
    end
    c_p_valid = 1'b1; c_p_hart = 32'd1; rsp_ready = 2'b10;
    #1;
    checks++;
    if (rsp_valid !== 2'b10 || c_p_ready !== 1'b1) begin
      errors++;
      $display("FAIL thr_rsp: got valid=%b ready=%b expected 10 1", rsp_valid, c_p_ready);
    end
    tick();
    c_p_valid = 1'b0;
    checks++;
    if (outstanding[1] !== 4'd3) begin
      errors++;
      $display("FAIL thr_count_dec: got %0d expected 3", outstanding[1]);
    end
    c_q_ready = 1'b1;
    #1;
    tick();
    checks++;
    if (req_ready !== 2'b10 || c_q_hart !== 32'd1) begin
      errors++;
      $display("FAIL thr_reelig: got rdy=%b hart=%0d expected 10 hart=1", req_ready, c_q_hart);
    end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    set_payloads();
    req_valid = 2'b01; c_q_ready = 1'b1;
    tick(); tick();
    checks++;
    if (outstanding[0] !== 4'd2) begin
      errors++;
      $display("FAIL same_pre: got %0d expected 2", outstanding[0]);
    end
    c_p_valid = 1'b1; c_p_hart = 32'd0; rsp_ready = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01 || rsp_valid !== 2'b01) begin
      errors++;
      $display("FAIL same_hs: got rdy=%b rsp=%b expected 01 01", req_ready, rsp_valid);
    end
    tick();
    c_p_valid = 1'b0; req_valid = '0;
    #1;
    checks++;
    if (outstanding[0] !== 4'd2) begin
      errors++;
      $display("FAIL same_post: got %0d expected 2", outstanding[0]);
    end
  endtask

  task automatic test_bad_response();
    apply_reset();
    c_p_valid = 1'b1; c_p_hart = 32'd5; rsp_ready = '0;
    #1;
    checks++;
    if (c_p_ready !== 1'b1 || rsp_valid !== 2'b00 || err !== 1'b0) begin
      errors++;
      $display("FAIL bad_range: got rdy=%b rsp=%b err=%b expected 1 00 0", c_p_ready, rsp_valid, err);
    end
    tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL bad_err_set: got %b expected 1", err);
    end
    c_p_hart = 32'd0;
    #1;
    checks++;
    if (c_p_ready !== 1'b1 || rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL bad_zero_cnt: got rdy=%b rsp=%b expected 1 00", c_p_ready, rsp_valid);
    end
    tick();
    c_p_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL bad_err_sticky: got %b expected 1", err);
    end
    apply_reset();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL bad_err_clear: got %b expected 0", err);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_payloads();
    req_valid = 2'b01; c_q_ready = 1'b1;
    tick(); tick(); tick();
    req_valid = 2'b11; c_q_ready = 1'b0;
    #1;
    tick();
    checks++;
    if (c_q_valid !== 1'b1 || c_q_hart !== 32'd1 || outstanding[0] !== 4'd3) begin
      errors++;
      $display("FAIL mid_locked: got v=%b hart=%0d cnt0=%0d expected 1 1 3", c_q_valid, c_q_hart, outstanding[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({c_q_valid, req_ready, c_p_ready, rsp_valid} !== '0 || outstanding !== '0 || c_q_hart !== '0 || c_q_addr !== '0) begin
      errors++;
      $display("FAIL mid_async: got v=%b rdy=%b cnt=%h hart=%0d expected all 0", c_q_valid, req_ready, outstanding, c_q_hart);
    end
    m_reset();
    #1;
    rst = 1'b0;
    c_q_ready = 1'b1;
    c_p_valid = 1'b1; c_p_hart = 32'd0; rsp_ready = '1;
    #1;
    checks++;
    if (c_q_hart !== 32'd0 || req_ready !== 2'b01 || c_p_ready !== 1'b1 || rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL mid_after: got hart=%0d rdy=%b prdy=%b rsp=%b expected 0 01 1 00",
               c_q_hart, req_ready, c_p_ready, rsp_valid);
    end
    tick();
    c_p_valid = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL mid_err: got %b expected 1", err);
    end
  endtask

  task automatic test_random();
    bit v, ok;
    int g, o;
    logic [N-1:0] rv;
    logic [N-1:0] exp_rdy, exp_rsp;
    logic exp_prdy;
    apply_reset();
    set_payloads();
    for (int cyc = 0; cyc < 400; cyc++) begin
      rv = N'($urandom_range(0, 3));
      if (m_locked) rv[m_gnt] = 1'b1;
      req_valid = rv;
      for (int i = 0; i < N; i++) begin
        if (!(m_locked && m_gnt == i)) begin
          req_addr[i]  = $urandom;
          req_instr[i] = $urandom;
          for (int r = 0; r < 3; r++) req_rs[i][r] = $urandom;
        end
      end
      c_q_ready = ($urandom_range(0, 2) != 0);
      c_p_valid = ($urandom_range(0, 1) != 0);
      c_p_hart  = ($urandom_range(0, 15) != 0) ? 32'($urandom_range(0, 1)) : 32'($urandom_range(2, 7));
      rsp_ready = N'($urandom);
      c_p_data  = $urandom;
      #1;
      m_pick(v, g);
      m_rsp(ok, o);
      exp_rdy  = (v && c_q_ready) ? N'(1 << g) : '0;
      exp_rsp  = (ok && c_p_valid) ? N'(1 << o) : '0;
      exp_prdy = ok ? rsp_ready[o] : 1'b1;
      checks++;
      if (c_q_valid !== v || req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rnd_grant[%0d]: got v=%b rdy=%b expected v=%b rdy=%b", cyc, c_q_valid, req_ready, v, exp_rdy);
      end
      if (v) begin
        checks++;
        if (c_q_hart !== 32'(g) || c_q_addr !== req_addr[g] || c_q_instr !== req_instr[g] || c_q_rs !== req_rs[g]) begin
          errors++;
          $display("FAIL rnd_payload[%0d]: got hart=%0d addr=%0h expected hart=%0d addr=%0h",
                   cyc, c_q_hart, c_q_addr, g, req_addr[g]);
        end
      end
      checks++;
      if (rsp_valid !== exp_rsp || c_p_ready !== exp_prdy) begin
        errors++;
        $display("FAIL rnd_rsp[%0d]: got rsp=%b prdy=%b expected rsp=%b prdy=%b", cyc, rsp_valid, c_p_ready, exp_rsp, exp_prdy);
      end
      tick();
      checks++;
      if (outstanding[0] !== 4'(m_cnt[0]) || outstanding[1] !== 4'(m_cnt[1]) || err !== m_err) begin
        errors++;
        $display("FAIL rnd_state[%0d]: got cnt=%h err=%b expected cnt=%0d,%0d err=%b",
                 cyc, outstanding, err, m_cnt[1], m_cnt[0], m_err);
      end
    end
    clear_inputs();
  endtask

  initial begin
    m_reset();
    test_reset();
    test_alternate();
    test_lock_hold();
    test_throttle();
    test_same_cycle();
    test_bad_response();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
